decode_stage: RTL and testbench

Second pipeline stage of the RV32i core, directly downstream of fetch. Holds the IF/ID pipeline register and the 32×32 register file. Decodes the registered instruction into:
- register operands;
- a sign-extended immediate;
- control signals for execute.

Supports stall (hold) and flush (bubble insertion) from the hazard unit, and accepts the writeback port.

---
 rtl/definitions.sv | 68 ++++++
 rtl/reg_file.sv | 35 +++
 rtl/decode_stage.sv | 177 +++++++++++++++++
 tb/tb_decode_stage.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/definitions.sv
// Shared RV32I decode types: ALU operations, immediate formats, opcodes and the NOP encoding.
package definitions;

  typedef enum logic [3:0] {
    AluAdd   = 4'd0,
    AluSub   = 4'd1,
    AluSll   = 4'd2,
    AluSlt   = 4'd3,
    AluSltu  = 4'd4,
    AluXor   = 4'd5,
    AluSrl   = 4'd6,
    AluSra   = 4'd7,
    AluOr    = 4'd8,
    AluAnd   = 4'd9,
    AluPassB = 4'd10
  } alu_op_t;

  typedef enum logic [2:0] {
    ImmNone,
    ImmI,
    ImmS,
    ImmB,
    ImmU,
    ImmJ
  } imm_type_t;

  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;

  localparam logic [31:0] Nop = 32'h00000013;

  function automatic logic [31:0] gen_imm(input imm_type_t t, input logic [31:0] i);
    logic [31:0] imm;
    case (t)
      ImmI:    imm = {{20{i[31]}}, i[31:20]};
      ImmS:    imm = {{20{i[31]}}, i[31:25], i[11:7]};
      ImmB:    imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      ImmU:    imm = {i[31:12], 12'b0};
      ImmJ:    imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

  // alt selects SUB/SRA; the caller decides when funct7[5] is meaningful.
  function automatic alu_op_t alu_from_funct(input logic [2:0] f3, input logic alt);
    alu_op_t op;
    case (f3)
      3'b000:  op = alt ? AluSub : AluAdd;
      3'b001:  op = AluSll;
      3'b010:  op = AluSlt;
      3'b011:  op = AluSltu;
      3'b100:  op = AluXor;
      3'b101:  op = alt ? AluSra : AluSrl;
      3'b110:  op = AluOr;
      default: op = AluAnd;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/reg_file.sv
// 32x32 register file: two async read ports, one sync write port, x0 hardwired to zero.
// Optional same-cycle write-through when REG_BYPASS_EN is defined.
module reg_file
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2
);

  logic [31:0] regs_q [32];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (we && (waddr != 5'd0)) begin
      regs_q[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata1 = (raddr1 == 5'd0) ? 32'd0 : regs_q[raddr1];
    rdata2 = (raddr2 == 5'd0) ? 32'd0 : regs_q[raddr2];
`ifdef REG_BYPASS_EN
    if (we && (waddr != 5'd0) && (waddr == raddr1)) rdata1 = wdata;
    if (we && (waddr != 5'd0) && (waddr == raddr2)) rdata2 = wdata;
`endif
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: IF/ID register with stall/flush, register file and control decode.
// Define REG_BYPASS_EN for register-file write-through on same-cycle read/write.
module decode_stage
  import definitions::*;
#(
  parameter logic [31:0] RESET_INSTR = Nop
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ID_En,
  input  logic        Flush,
  input  logic [31:0] Instr,
  input  logic [31:0] PC,
  input  logic [31:0] PC_Plus_4,
  input  logic        WB_Reg_Write,
  input  logic [4:0]  WB_RD_Addr,
  input  logic [31:0] WB_Result,
  output logic [31:0] ID_PC,
  output logic [31:0] ID_PC_Plus_4,
  output logic        ID_Valid,
  output logic [4:0]  RS1_Addr,
  output logic [4:0]  RS2_Addr,
  output logic [4:0]  RD_Addr,
  output logic [31:0] RD1,
  output logic [31:0] RD2,
  output logic [31:0] Imm,
  output alu_op_t     ALU_Op,
  output logic        ALU_Src,
  output logic        Reg_Write,
  output logic        Mem_Read,
  output logic        Mem_Write,
  output logic        Branch,
  output logic        Jump,
  output logic        Illegal
);

  logic [31:0] instr_q, pc_q, pc4_q;
  logic        valid_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      instr_q <= RESET_INSTR;
      pc_q    <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else if (Flush) begin
      instr_q <= RESET_INSTR;
      pc_q    <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else if (ID_En) begin
      instr_q <= Instr;
      pc_q    <= PC;
      pc4_q   <= PC_Plus_4;
      valid_q <= 1'b1;
    end
  end

  assign ID_PC        = pc_q;
  assign ID_PC_Plus_4 = pc4_q;
  assign ID_Valid     = valid_q;
  assign RS1_Addr     = instr_q[19:15];
  assign RS2_Addr     = instr_q[24:20];
  assign RD_Addr      = instr_q[11:7];

  reg_file u_reg_file (
    .clk    (CLK),
    .rst_n  (RST),
    .we     (WB_Reg_Write),
    .waddr  (WB_RD_Addr),
    .wdata  (WB_Result),
    .raddr1 (instr_q[19:15]),
    .raddr2 (instr_q[24:20]),
    .rdata1 (RD1),
    .rdata2 (RD2)
  );

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  imm_type_t  imm_type;

  assign opcode = instr_q[6:0];
  assign funct3 = instr_q[14:12];
  assign funct7 = instr_q[31:25];
  assign Imm    = gen_imm(imm_type, instr_q);

  always_comb begin
    imm_type  = ImmNone;
    ALU_Op    = AluAdd;
    ALU_Src   = 1'b0;
    Reg_Write = 1'b0;
    Mem_Read  = 1'b0;
    Mem_Write = 1'b0;
    Branch    = 1'b0;
    Jump      = 1'b0;
    Illegal   = 1'b0;
    case (opcode)
      OpcOp: begin
        Reg_Write = 1'b1;
        // funct7=0100000 is only defined for SUB and SRA
        if ((funct7 == 7'b0000000) ||
            ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)))) begin
          ALU_Op = alu_from_funct(funct3, funct7[5]);
        end else begin
          Illegal = 1'b1;
        end
      end
      OpcOpImm: begin
        imm_type  = ImmI;
        ALU_Src   = 1'b1;
        Reg_Write = 1'b1;
        ALU_Op    = alu_from_funct(funct3, (funct3 == 3'b101) && funct7[5]);
      end
      OpcLoad: begin
        imm_type  = ImmI;
        ALU_Src   = 1'b1;
        Reg_Write = 1'b1;
        Mem_Read  = 1'b1;
      end
      OpcStore: begin
        imm_type  = ImmS;
        ALU_Src   = 1'b1;
        Mem_Write = 1'b1;
      end
      OpcBranch: begin
        imm_type = ImmB;
        ALU_Op   = AluSub;
        Branch   = 1'b1;
      end
      OpcJal: begin
        imm_type  = ImmJ;
        ALU_Src   = 1'b1;
        Reg_Write = 1'b1;
        Jump      = 1'b1;
      end
      OpcJalr: begin
        imm_type  = ImmI;
        ALU_Src   = 1'b1;
        Reg_Write = 1'b1;
        Jump      = 1'b1;
      end
      OpcLui: begin
        imm_type  = ImmU;
        ALU_Src   = 1'b1;
        Reg_Write = 1'b1;
        ALU_Op    = AluPassB;
      end
      OpcAuipc: begin
        imm_type  = ImmU;
        ALU_Src   = 1'b1;
        Reg_Write = 1'b1;
      end
      default: Illegal = 1'b1;
    endcase

    if (Illegal) begin
      Reg_Write = 1'b0;
      Mem_Read  = 1'b0;
      Mem_Write = 1'b0;
      Branch    = 1'b0;
      Jump      = 1'b0;
    end

    // A bubble must never write, branch or trap.
    if (!valid_q) begin
      ALU_Src   = 1'b0;
      Reg_Write = 1'b0;
      Mem_Read  = 1'b0;
      Mem_Write = 1'b0;
      Branch    = 1'b0;
      Jump      = 1'b0;
      Illegal   = 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: decode vector table through a scoreboard,
// plus hand-written writeback, x0, stall/flush and async-reset sequences.
module tb_decode_stage;
  import definitions::*;

  logic        CLK = 1'b0;
  logic        RST, ID_En, Flush, WB_Reg_Write;
  logic [31:0] Instr, PC, PC_Plus_4, WB_Result;
  logic [4:0]  WB_RD_Addr;
  logic [31:0] ID_PC, ID_PC_Plus_4, RD1, RD2, Imm;
  logic        ID_Valid, ALU_Src, Reg_Write, Mem_Read, Mem_Write, Branch, Jump, Illegal;
  logic [4:0]  RS1_Addr, RS2_Addr, RD_Addr;
  alu_op_t     ALU_Op;

  decode_stage dut (
    .CLK          (CLK),
    .RST          (RST),
    .ID_En        (ID_En),
    .Flush        (Flush),
    .Instr        (Instr),
    .PC           (PC),
    .PC_Plus_4    (PC_Plus_4),
    .WB_Reg_Write (WB_Reg_Write),
    .WB_RD_Addr   (WB_RD_Addr),
    .WB_Result    (WB_Result),
    .ID_PC        (ID_PC),
    .ID_PC_Plus_4 (ID_PC_Plus_4),
    .ID_Valid     (ID_Valid),
    .RS1_Addr     (RS1_Addr),
    .RS2_Addr     (RS2_Addr),
    .RD_Addr      (RD_Addr),
    .RD1          (RD1),
    .RD2          (RD2),
    .Imm          (Imm),
    .ALU_Op       (ALU_Op),
    .ALU_Src      (ALU_Src),
    .Reg_Write    (Reg_Write),
    .Mem_Read     (Mem_Read),
    .Mem_Write    (Mem_Write),
    .Branch       (Branch),
    .Jump         (Jump),
    .Illegal      (Illegal)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    alu_op_t     alu;
    logic        src;
    logic [4:0]  ctrl;  // {reg_write, mem_read, mem_write, branch, jump}
    logic        ill;
  } vec_t;

  localparam int NumVec = 15;
  vec_t vecs [NumVec];
  vec_t sb [$];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic vec_t mk(input logic [31:0] instr, input logic [31:0] pc,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                              input logic [31:0] imm, input alu_op_t alu, input logic src,
                              input logic [4:0] ctrl, input logic ill);
    vec_t v;
    v.instr = instr; v.pc = pc; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
    v.imm = imm; v.alu = alu; v.src = src; v.ctrl = ctrl; v.ill = ill;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    vec_t e;
    vecs[0]  = mk(32'h00200093, 32'h000, 5'd0,  5'd2,  5'd1,  32'h00000002, AluAdd,   1, 5'b10000, 0);
    vecs[1]  = mk(32'h407302B3, 32'h004, 5'd6,  5'd7,  5'd5,  32'h00000000, AluSub,   0, 5'b10000, 0);
    vecs[2]  = mk(32'hFF812403, 32'h008, 5'd2,  5'd24, 5'd8,  32'hFFFFFFF8, AluAdd,   1, 5'b11000, 0);
    vecs[3]  = mk(32'h00952A23, 32'h00C, 5'd10, 5'd9,  5'd20, 32'h00000014, AluAdd,   1, 5'b00100, 0);
    vecs[4]  = mk(32'hFE000EE3, 32'h010, 5'd0,  5'd0,  5'd29, 32'hFFFFFFFC, AluSub,   0, 5'b00010, 0);
    vecs[5]  = mk(32'h008000EF, 32'h014, 5'd0,  5'd8,  5'd1,  32'h00000008, AluAdd,   1, 5'b10001, 0);
    vecs[6]  = mk(32'h00008067, 32'h018, 5'd1,  5'd0,  5'd0,  32'h00000000, AluAdd,   1, 5'b10001, 0);
    vecs[7]  = mk(32'h12345137, 32'h01C, 5'd8,  5'd3,  5'd2,  32'h12345000, AluPassB, 1, 5'b10000, 0);
    vecs[8]  = mk(32'hFFFFF197, 32'h020, 5'd31, 5'd31, 5'd3,  32'hFFFFF000, AluAdd,   1, 5'b10000, 0);
    vecs[9]  = mk(32'h00000000, 32'h024, 5'd0,  5'd0,  5'd0,  32'h00000000, AluAdd,   0, 5'b00000, 1);
    vecs[10] = mk(32'h02000033, 32'h028, 5'd0,  5'd0,  5'd0,  32'h00000000, AluAdd,   0, 5'b00000, 1);
    vecs[11] = mk(32'h40315093, 32'h02C, 5'd2,  5'd3,  5'd1,  32'h00000403, AluSra,   1, 5'b10000, 0);
    vecs[12] = mk(32'h0062B233, 32'h030, 5'd5,  5'd6,  5'd4,  32'h00000000, AluSltu,  0, 5'b10000, 0);
    vecs[13] = mk(32'hFFF3C393, 32'h034, 5'd7,  5'd31, 5'd7,  32'hFFFFFFFF, AluXor,   1, 5'b10000, 0);
    vecs[14] = mk(32'h40001033, 32'h038, 5'd0,  5'd0,  5'd0,  32'h00000000, AluAdd,   0, 5'b00000, 1);

    RST = 1'b0; ID_En = 1'b0; Flush = 1'b0; Instr = '0; PC = '0; PC_Plus_4 = '0;
    WB_Reg_Write = 1'b0; WB_RD_Addr = '0; WB_Result = '0;

    // Reset state
    #12;
    check("rst_valid", {31'd0, ID_Valid}, 32'd0);
    check("rst_pc", ID_PC, 32'd0);
    check("rst_rd1", RD1, 32'd0);
    check("rst_rd2", RD2, 32'd0);
    check("rst_imm", Imm, 32'd0);
    check("rst_ctrl", {26'd0, ALU_Src, Reg_Write, Mem_Read, Mem_Write, Branch, Jump}, 32'd0);
    check("rst_illegal", {31'd0, Illegal}, 32'd0);
    RST = 1'b1;

    // Decode table through the scoreboard
    for (int i = 0; i < NumVec; i++) begin
      ID_En = 1'b1;
      Instr = vecs[i].instr;
      PC = vecs[i].pc;
      PC_Plus_4 = vecs[i].pc + 32'd4;
      sb.push_back(vecs[i]);
      tick();
      if (sb.size() == 0) begin
        check("sb_empty", 32'd0, 32'd1);
      end else begin
        e = sb.pop_front();
        check("valid", {31'd0, ID_Valid}, 32'd1);
        check("id_pc", ID_PC, e.pc);
        check("id_pc4", ID_PC_Plus_4, e.pc + 32'd4);
        check("rs1", {27'd0, RS1_Addr}, {27'd0, e.rs1});
        check("rs2", {27'd0, RS2_Addr}, {27'd0, e.rs2});
        check("rd", {27'd0, RD_Addr}, {27'd0, e.rd});
        check("imm", Imm, e.imm);
        check("alu_op", {28'd0, ALU_Op}, {28'd0, e.alu});
        check("alu_src", {31'd0, ALU_Src}, {31'd0, e.src});
        check("ctrl", {27'd0, Reg_Write, Mem_Read, Mem_Write, Branch, Jump}, {27'd0, e.ctrl});
        check("illegal", {31'd0, Illegal}, {31'd0, e.ill});
      end
    end

    // Writeback to x3 while decoding ADD x3,x1,x2, then ADD x4,x3,x3
    Instr = 32'h002081b3;
    tick();
    check("wb_rs2_addr", {27'd0, RS2_Addr}, 32'd2);
    check("wb_rd2_x2", RD2, 32'd0);
    WB_Reg_Write = 1'b1; WB_RD_Addr = 5'd3; WB_Result = 32'h55;
    Instr = 32'h00318233;
    tick();
    WB_Reg_Write = 1'b0;
    #1;
    check("wb_rd1_x3", RD1, 32'h55);
    check("wb_rd2_x3", RD2, 32'h55);
    // Stalled, overwrite x3: bypass decides the same-cycle value
    ID_En = 1'b0;
    WB_Reg_Write = 1'b1; WB_RD_Addr = 5'd3; WB_Result = 32'h77;
    #1;
`ifdef REG_BYPASS_EN
    check("bypass_rd1", RD1, 32'h77);
`else
    check("nobypass_rd1", RD1, 32'h55);
`endif
    tick();
    WB_Reg_Write = 1'b0;
    #1;
    check("stall_track_rd1", RD1, 32'h77);
    check("stall_track_rd2", RD2, 32'h77);
    check("stall_rd_addr", {27'd0, RD_Addr}, 32'd4);

    // Writes to x0 are discarded
    ID_En = 1'b1; Instr = 32'h00200093;
    tick();
    ID_En = 1'b0;
    WB_Reg_Write = 1'b1; WB_RD_Addr = 5'd0; WB_Result = 32'hDEAD;
    #1;
    check("x0_same_cycle", RD1, 32'd0);
    tick();
    WB_Reg_Write = 1'b0;
    #1;
    check("x0_after", RD1, 32'd0);

    // Stall three cycles with fetch changing, then flush during stall
    ID_En = 1'b1; Instr = 32'h00200093; PC = 32'h100; PC_Plus_4 = 32'h104;
    tick();
    ID_En = 1'b0;
    for (int k = 0; k < 3; k++) begin
      Instr = $urandom;
      PC = $urandom;
      PC_Plus_4 = $urandom;
      tick();
      check("stall_rd", {27'd0, RD_Addr}, 32'd1);
      check("stall_imm", Imm, 32'd2);
      check("stall_pc", ID_PC, 32'h100);
      check("stall_pc4", ID_PC_Plus_4, 32'h104);
      check("stall_regwrite", {31'd0, Reg_Write}, 32'd1);
    end
    Flush = 1'b1;
    tick();
    Flush = 1'b0;
    check("flush_valid", {31'd0, ID_Valid}, 32'd0);
    check("flush_imm", Imm, 32'd0);
    check("flush_rd", {27'd0, RD_Addr}, 32'd0);
    check("flush_pc", ID_PC, 32'd0);
    check("flush_regwrite", {31'd0, Reg_Write}, 32'd0);
    check("flush_illegal", {31'd0, Illegal}, 32'd0);

    // Write x5=7 while loading ADD x1,x5,x0, then async reset mid-cycle
    ID_En = 1'b1; Instr = 32'h000280B3;
    WB_Reg_Write = 1'b1; WB_RD_Addr = 5'd5; WB_Result = 32'd7;
    tick();
    ID_En = 1'b0; WB_Reg_Write = 1'b0;
    #1;
    check("x5_written", RD1, 32'd7);
    #1;
    RST = 1'b0;
    #1;
    check("async_rst_rd1", RD1, 32'd0);
    check("async_rst_valid", {31'd0, ID_Valid}, 32'd0);
    check("async_rst_regwrite", {31'd0, Reg_Write}, 32'd0);
    #1;
    RST = 1'b1;
    ID_En = 1'b1; Instr = 32'h00200093; PC = 32'h200; PC_Plus_4 = 32'h204;
    tick();
    check("post_rst_valid", {31'd0, ID_Valid}, 32'd1);
    check("post_rst_pc", ID_PC, 32'h200);
    check("post_rst_rd", {27'd0, RD_Addr}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
